// File: rtl/oric_sdram_bridge.sv
// Oric RAM strobes to SDRAM toggle-handshake bridge (clk_72 domain).
// Tracks one outstanding request plus a one-deep pending slot.
module oric_sdram_bridge #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              res_n_i,
  input  logic [ADDR_W-1:0] ram_ad,
  input  logic [7:0]        ram_d,
  input  logic              ram_cs,
  input  logic              ram_oe,
  input  logic              ram_we,
  output logic [7:0]        ram_q,
  output logic              port_req,
  input  logic              port_ack,
  output logic [ADDR_W-1:0] port_a,
  output logic              port_we,
  output logic [1:0]        port_ds,
  output logic [15:0]       port_d,
  input  logic [15:0]       port_q,
  output logic              busy,
  output logic              timeout_flag,
  output logic              overrun_flag
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e            state_q;
  logic              rd_q, wr_q, rd_p_q, wr_p_q;
  logic [ADDR_W-1:0] ad_q, ad_p_q;
  logic [7:0]        d_q;
  logic              req_q, we_q;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        ds_q;
  logic [15:0]       pd_q;
  logic [7:0]        q_reg_q;
  logic [CW-1:0]     cnt_q;
  logic              pv_q, pwe_q;
  logic [ADDR_W-1:0] pa_q;
  logic [7:0]        pdat_q;
  logic              to_q, ov_q;

  logic              ev_d, ev_we_d;
  logic              iss_we_d;
  logic [ADDR_W-1:0] iss_a_d;
  logic [7:0]        iss_dat_d;
  logic [1:0]        iss_ds_d;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_p_q <= 1'b0;
      wr_p_q <= 1'b0;
      ad_q   <= '0;
      ad_p_q <= '0;
      d_q    <= '0;
    end else begin
      rd_q   <= ram_cs & ram_oe;
      wr_q   <= ram_cs & ram_we;
      ad_q   <= ram_ad;
      d_q    <= ram_d;
      rd_p_q <= rd_q;
      wr_p_q <= wr_q;
      ad_p_q <= ad_q;
    end
  end

  always_comb begin
    ev_d = (rd_q & ~rd_p_q)
         | (wr_q & ~wr_p_q)
         | (rd_q & rd_p_q & (ad_q != ad_p_q));
    ev_we_d   = wr_q & ~wr_p_q;
    iss_we_d  = pv_q ? pwe_q  : ev_we_d;
    iss_a_d   = pv_q ? pa_q   : ad_q;
    iss_dat_d = pv_q ? pdat_q : d_q;
    if (!iss_we_d)      iss_ds_d = 2'b11;
    else if (iss_a_d[0]) iss_ds_d = 2'b10;
    else                iss_ds_d = 2'b01;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      ds_q    <= 2'b11;
      pd_q    <= '0;
      q_reg_q <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pwe_q   <= 1'b0;
      pa_q    <= '0;
      pdat_q  <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pv_q | ev_d) begin
            a_q     <= iss_a_d;
            we_q    <= iss_we_d;
            ds_q    <= iss_ds_d;
            pd_q    <= {iss_dat_d, iss_dat_d};
            req_q   <= ~req_q;
            cnt_q   <= '0;
            state_q <= WAIT;
          end
          // Pending goes out first; a same-cycle event refills the slot.
          pv_q <= pv_q & ev_d;
          if (pv_q & ev_d) begin
            pwe_q  <= ev_we_d;
            pa_q   <= ad_q;
            pdat_q <= d_q;
          end
        end
        WAIT: begin
          if (ev_d) begin
            if (pv_q & pwe_q) begin
              ov_q <= 1'b1;
            end else begin
              pv_q   <= 1'b1;
              pwe_q  <= ev_we_d;
              pa_q   <= ad_q;
              pdat_q <= d_q;
            end
          end
          if (port_ack == req_q) begin
            if (!we_q)
              q_reg_q <= a_q[0] ? port_q[15:8] : port_q[7:0];
            state_q <= IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            to_q <= 1'b1;
            if (!we_q) q_reg_q <= 8'hFF;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_q        = ram_cs ? q_reg_q : 8'h00;
  assign port_req     = req_q;
  assign port_a       = a_q;
  assign port_we      = we_q;
  assign port_ds      = ds_q;
  assign port_d       = pd_q;
  assign busy         = (state_q != IDLE) | pv_q;
  assign timeout_flag = to_q;
  assign overrun_flag = ov_q;

endmodule
